// File: rtl/rv32i_control_pkg.sv
// rv32i_control_pkg
//   Shared types and constants for the RV32I front end.
//   fetch_entry_t : one fetched instruction word tagged with its PC.
//   FETCH_PC_STEP : PC increment between sequential fetches.
//   word_align()  : clears the byte-offset bits of an address.
package rv32i_control_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] FETCH_PC_STEP = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/rv32i_fetch_fifo.sv
// rv32i_fetch_fifo
//   Synchronous FIFO with a registered head entry, used as the IF->ID
//   instruction queue.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   push_i/data_i  write an entry at the tail (caller never pushes when full)
//   pop_i          remove the head entry (ignored when empty)
//   flush_i        discard all entries at the clock edge
//   full_o/empty_o occupancy flags
//   count_o        number of stored entries ($clog2(DEPTH)+1 bits)
//   head_o         registered copy of the oldest entry
module rv32i_fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic [63:0]
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  T                           data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output T                           head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] CNT_ONE  = PW'(1);
  localparam logic [PW-1:0] CNT_FULL = PW'(DEPTH);

  T              mem_q [DEPTH];
  T              head_q, head_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_idx, rd_idx_next;
  logic          pop_ok;

  // Pointers carry one extra wrap bit, so the difference is the fill level
  // and full/empty are distinguishable.
  assign count_o     = wr_ptr_q - rd_ptr_q;
  assign empty_o     = (count_o == '0);
  assign full_o      = (count_o == CNT_FULL);
  assign head_o      = head_q;
  assign wr_idx      = wr_ptr_q[AW-1:0];
  assign rd_idx_next = rd_ptr_q[AW-1:0] + AW'(1);
  assign pop_ok      = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, push_i};
    rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop_ok};
    head_d   = head_q;
    // The head register must always mirror the oldest entry: it takes the
    // incoming word when it becomes the oldest, otherwise the next stored one.
    if (push_i && (empty_o || (pop_ok && count_o == CNT_ONE))) begin
      head_d = data_i;
    end else if (pop_ok && count_o > CNT_ONE) begin
      head_d = mem_q[rd_idx_next];
    end
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end

  // Storage has no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem_q[wr_idx] <= data_i;
    end
  end

endmodule

// File: rtl/rv32i_fetch_queue.sv
// rv32i_fetch_queue
//   IF stage: owns the fetch PC, issues in-order word fetches to instruction
//   memory and buffers returned words (with their PC) for ID.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   imem_req_o/addr_o     fetch request and word-aligned address
//   imem_gnt_i            request accepted this cycle
//   imem_rvalid_i/rdata_i in-order response
//   stall_i               hold the ID head entry
//   flush_i/redirect_pc_i drop queued and in-flight words, restart fetch
//   id_valid_o/instr_o/pc_o  head entry presented to ID
module rv32i_fetch_queue
  import rv32i_control_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic [CW:0]   in_flight;
  logic          fire, resp_push, fifo_push, fifo_pop;
  logic [31:0]   redirect_aligned;
  fetch_entry_t  push_entry, head_entry;

  // Credit: queued words plus live requests may never exceed the queue
  // depth, so every live response is guaranteed a free slot.
  assign in_flight  = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign imem_req_o = !rst_i && !flush_i && (in_flight < (CW+1)'(DEPTH));
  assign imem_addr_o = fetch_pc_q;
  assign fire       = imem_req_o && imem_gnt_i;

  // Responses to requests issued before a flush are counted in discard and
  // thrown away; anything arriving in the flush cycle is also dropped.
  assign resp_push  = imem_rvalid_i && (discard_q == '0) && !flush_i;
  assign fifo_push  = resp_push && !fifo_full;
  assign fifo_pop   = !fifo_empty && !stall_i && !flush_i;

  assign redirect_aligned = word_align(redirect_pc_i);
  assign push_entry       = '{pc: resp_pc_q, instr: imem_rdata_i};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (flush_i) begin
      fetch_pc_d    = redirect_aligned;
      resp_pc_d     = redirect_aligned;
      outstanding_d = '0;
      discard_d     = discard_q + outstanding_q - {{(CW-1){1'b0}}, imem_rvalid_i};
    end else begin
      if (fire) begin
        fetch_pc_d = fetch_pc_q + FETCH_PC_STEP;
      end
      if (resp_push) begin
        resp_pc_d = resp_pc_q + FETCH_PC_STEP;
      end
      outstanding_d = outstanding_q + {{(CW-1){1'b0}}, fire}
                                    - {{(CW-1){1'b0}}, resp_push};
      if (imem_rvalid_i && discard_q != '0) begin
        discard_d = discard_q - {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  rv32i_fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .flush_i (flush_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (head_entry)
  );

  assign id_valid_o = !fifo_empty;
  assign id_instr_o = head_entry.instr;
  assign id_pc_o    = head_entry.pc;

`ifdef ENABLE_ASSERTIONS
  logic        hold_q;
  logic [31:0] hold_addr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= 1'b0;
    end else begin
      hold_q <= imem_req_o && !imem_gnt_i && !flush_i;
    end
    hold_addr_q <= imem_addr_o;
    if (!rst_i) begin
      assert (!(imem_rvalid_i && outstanding_q == '0 && discard_q == '0));
      assert (!(resp_push && fifo_full));
      if (hold_q) begin
        assert (imem_addr_o == hold_addr_q);
      end
    end
  end
`endif

endmodule
